// File: rtl/alu_mc.sv
// alu_mc: N-bit ALU with valid/ready command and result handshakes.
// Single-cycle ops finish in one cycle; MUL iterates over N cycles.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   in_valid/in_ready command handshake (op, a, b sampled on accept)
//   op, a, b          opcode and signed operands
//   out_valid/ready   result handshake
//   result, onz, err  result, {overflow, negative, zero}, illegal-op flag
module alu_mc #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [2:0]   onz,
   output logic         err
);

   localparam int SW = $clog2(N);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_INC  = 4'd5;
   localparam logic [3:0] OP_MOVA = 4'd6;
   localparam logic [3:0] OP_MOVB = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_SRL  = 4'd11;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t         state_q;
   logic [N-1:0]   res_q;
   logic [2:0]     onz_q;
   logic           err_q;
   logic [2*N-1:0] acc_q;
   logic [2*N-1:0] mcand_q;
   logic [N-1:0]   mplier_q;
   logic [SW-1:0]  cnt_q;

   logic           accept;
   logic [SW-1:0]  sh;
   logic [N-1:0]   alu_res;
   logic           alu_ovf;
   logic           alu_err;
   logic [2:0]     alu_onz;
   logic [2*N-1:0] term;
   logic [2*N-1:0] prod_d;
   logic [N-1:0]   mul_lo;
   logic           mul_ovf;
   logic           last_it;

   assign in_ready  = (state_q == IDLE) ||
                      (state_q == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign onz       = onz_q;
   assign err       = err_q;

   assign sh = b[SW-1:0];

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_err = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = a + b;
            alu_ovf = (a[N-1] == b[N-1]) &&
                      (alu_res[N-1] != a[N-1]);
         end
         OP_SUB: begin
            alu_res = a - b;
            alu_ovf = (a[N-1] != b[N-1]) &&
                      (alu_res[N-1] != a[N-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_INC: begin
            alu_res = a + N'(1);
            alu_ovf = (a == {1'b0, {(N-1){1'b1}}});
         end
         OP_MOVA: alu_res = a;
         OP_MOVB: alu_res = b;
         OP_MUL:  alu_res = '0;
         OP_SHL:  alu_res = a << sh;
         OP_SRA:  alu_res = $signed(a) >>> sh;
         OP_SRL:  alu_res = a >> sh;
         default: alu_err = 1'b1;
      endcase
   end

   assign alu_onz = {alu_ovf, alu_res[N-1], alu_res == '0};

   // Signed shift-add: the MSB of b carries weight -2^(N-1),
   // so the last partial product is subtracted. The 2N-bit
   // accumulator then holds the exact signed product.
   assign last_it = (cnt_q == SW'(N-1));
   always_comb begin
      term = '0;
      if (mplier_q[0])
         term = last_it ? (~mcand_q + 1'b1) : mcand_q;
   end
   assign prod_d  = acc_q + term;
   assign mul_lo  = prod_d[N-1:0];
   assign mul_ovf = (prod_d[2*N-1:N] != {N{prod_d[N-1]}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         res_q    <= '0;
         onz_q    <= '0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     state_q  <= BUSY;
                     acc_q    <= '0;
                     mcand_q  <= {{N{a[N-1]}}, a};
                     mplier_q <= b;
                     cnt_q    <= '0;
                  end else begin
                     state_q <= DONE;
                     res_q   <= alu_res;
                     onz_q   <= alu_onz;
                     err_q   <= alu_err;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               acc_q    <= prod_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + SW'(1);
               if (last_it) begin
                  state_q <= DONE;
                  res_q   <= mul_lo;
                  onz_q   <= {mul_ovf, mul_lo[N-1], mul_lo == '0};
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (N=8).
// Driver pushes model results on accept; monitor pops on consume.
module tb_alu_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] op = '0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic [2:0] onz;
   logic       err;

   alu_mc #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .onz       (onz),
      .err       (err)
   );

   always #5 clk = ~clk;

   int          vecs = 0;
   int          errs = 0;
   logic [11:0] q[$];
   bit          rand_rdy = 0;
   bit          hold_v = 0;
   logic [12:0] hold_val;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: {result, O, N, Z, err} from plain integer arithmetic
   function automatic logic [11:0] model(input logic [3:0] o,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
      int sa, sb, full, k;
      logic [7:0] r;
      logic v, e;
      sa = int'($signed(x));
      sb = int'($signed(y));
      k = int'(y) % 8;
      full = 0;
      r = '0;
      v = 1'b0;
      e = 1'b0;
      case (o)
         4'd0:  full = sa + sb;
         4'd1:  full = sa - sb;
         4'd5:  full = sa + 1;
         4'd8:  full = sa * sb;
         4'd10: full = sa >>> k;
         default: full = 0;
      endcase
      case (o)
         4'd0, 4'd1, 4'd5, 4'd8: begin
            r = full[7:0];
            v = (full > 127) || (full < -128);
         end
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = x ^ y;
         4'd6:  r = x;
         4'd7:  r = y;
         4'd9:  r = x << k;
         4'd10: r = full[7:0];
         4'd11: r = x >> k;
         default: e = 1'b1;
      endcase
      return {r, v, r[7], r == 8'd0, e};
   endfunction

   // Monitor: pop on consume, and check output stability under stall
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 0;
      end else begin
         if (hold_v)
            chk("hold_stable", {out_valid, result, onz, err}, hold_val);
         if (out_valid && out_ready) begin
            if (q.size() == 0)
               chk("spurious_out", 1, 0);
            else
               chk("result", {result, onz, err}, q.pop_front());
         end
         hold_v = out_valid && !out_ready;
         hold_val = {out_valid, result, onz, err};
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Called at posedge+1; returns at accept edge+1
   task automatic send(input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y);
      int n;
      n = 0;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      else q.push_back(model(o, x, y));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 4'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
   endtask

   task automatic wait_valid(output int lat, output bit busy_ok);
      lat = 1;
      busy_ok = 1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit bok;
      bit stale;
      int n;

      #12;
      chk("reset_outs", {out_valid, result, onz, err}, 13'd0);
      #5 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);

      out_ready = 1'b1;
      send(4'd0, 8'd100, 8'd50);
      chk("add_lat", out_valid, 1);
      chk("add_val", {result, onz, err}, {8'h96, 3'b110, 1'b0});

      send(4'd1, 8'h80, 8'd1);
      chk("sub_val", {result, onz, err}, {8'h7F, 3'b100, 1'b0});
      send(4'd8, 8'd12, 8'hF6);
      wait_valid(lat, bok);
      chk("mul_lat", lat, 9);
      chk("mul_busy_ready", bok, 1);
      chk("mul_val", {result, onz, err}, {8'h88, 3'b010, 1'b0});

      send(4'd8, 8'd16, 8'd16);
      wait_valid(lat, bok);
      chk("mul_ovf_val", {result, onz, err}, {8'h00, 3'b101, 1'b0});
      send(4'd10, 8'h80, 8'h0B);
      chk("sra_val", {result, onz, err}, {8'hF0, 3'b010, 1'b0});
      @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(4'd0, 8'd1, 8'd1);
      repeat (5) begin
         chk("bp_hold", {out_valid, in_ready, result},
             {1'b1, 1'b0, 8'd2});
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(4'd4, 8'hFF, 8'hFF);
      chk("no_bubble", out_valid, 1);
      chk("xor_val", {result, onz, err}, {8'h00, 3'b001, 1'b0});

      send(4'hD, 8'd5, 8'd7);
      chk("illegal_val", {result, onz, err}, {8'h00, 3'b001, 1'b1});
      send(4'd7, 8'd5, 8'h80);
      chk("movb_val", {result, onz, err}, {8'h80, 3'b010, 1'b0});

      send(4'd8, 8'd3, 8'd5);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_busy_async", {out_valid, result, onz, err}, 13'd0);
      q.delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      stale = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      chk("no_stale", stale, 0);
      chk("rst_ready", in_ready, 1);
      @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(4'd0, 8'd3, 8'd4);
      chk("done_before_rst", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_done_async", {out_valid, result, onz, err}, 13'd0);
      q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      rand_rdy = 1;
      repeat (300)
         send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      rand_rdy = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      @(posedge clk);
      #1;
      chk("final_idle", {out_valid, in_ready}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Next-generation parametrised N-bit ALU. Operands and opcode are registered through a valid/ready handshake.
- Adds iterative signed multiply and barrel shifts to the existing 8-op set. Result and ONZ flags are held in output registers until consumed.
- Sits between the register-file read stage and the writeback stage of the datapath.

Parameters:
- N, 8, operand/result width in bits (N >= 4, power of 2).
- SW, $clog2(N), shift-amount width, derived; not overridden.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op/a/b valid.
- in_ready  out  1  block can accept a command.
- op  in  4  opcode.
- a  in  N  operand A, signed.
- b  in  N  operand B, signed.
- out_valid  out  1  result/onz/err valid.
- out_ready  in  1  consumer accepts result.
- result  out  N  result.
- onz  out  3  flags: [2] overflow, [1] negative, [0] zero.
- err  out  1  illegal opcode flag, qualified by out_valid.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except in_ready, which is 1 once rst deasserts. State goes to IDLE. An in-flight MUL is aborted with no output.
- States: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of MUL.
  - BUSY -> DONE when the cycle counter expires.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE or BUSY on out_ready with a simultaneous accept (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from state and out_ready only; it never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge. op, a and b are sampled only at accept and may change freely afterwards.
- Latency:
  - Single-cycle ops: out_valid is high in the cycle after the accept edge (latency 1).
  - MUL: out_valid is high N+1 cycles after the accept edge; BUSY lasts exactly N cycles.
  - Sustained throughput is 1 op/cycle for single-cycle ops while out_ready is held high.
- result, onz and err are stable while out_valid=1 and out_ready=0. They change only on a new result or on reset.
- out_valid drops the cycle after a consume unless a new result lands on the same edge.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 INC: a+1.
  - 6 MOVA: a.
  - 7 MOVB: b.
  - 8 MUL: low N bits of signed a*b, iterative over N cycles.
  - 9 SHL: a << b[SW-1:0].
  - 10 SRA: arithmetic a >> b[SW-1:0].
  - 11 SRL: logical a >> b[SW-1:0].
  - 12-15: illegal; result=0, onz=3'b001, err=1, latency 1.
- Arithmetic is modulo 2^N. Shift amounts use only b[SW-1:0]; upper bits of b are ignored.
- Overflow flag (O):
  - ADD: signed overflow (operands share a sign that differs from the result's sign).
  - SUB: signed overflow (a and b differ in sign, and the result's sign differs from a).
  - INC: 1 only when a = 2^(N-1)-1.
  - MUL: 1 if the full 2N-bit signed product is not the sign-extension of its low N bits.
  - All other opcodes: O=0.
- Negative flag = result[N-1]. Zero flag = (result == 0). Both apply to every opcode, including shifts and illegal opcodes.
- in_valid while BUSY is ignored (in_ready=0); the command is not lost at the source.
- Reset asserted during BUSY or DONE: the outputs clear asynchronously and the pending result is discarded.

Test Plan:
- N=8, ADD a=8'sd100, b=8'sd50, out_ready=1 -> result=8'h96 (-106), onz=3'b110, err=0, out_valid exactly 1 cycle after accept.
- N=8, SUB a=-128, b=1; then MUL a=8'sd12, b=-8'sd10 -> SUB: result=8'h7F, onz=3'b100. MUL: result=8'h88 (-120), onz=3'b010, out_valid 9 cycles after accept, in_ready=0 throughout BUSY.
- N=8, MUL a=8'sd16, b=8'sd16 -> result=8'h00, onz=3'b101 (overflow and zero). SRA a=8'h80, b=8'h0B -> shift by 3, result=8'hF0, onz=3'b010.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> result=2 and out_valid held stable, in_ready=0; out_ready=1 with a new XOR a=8'hFF, b=8'hFF accepted the same edge -> next result=0, onz=3'b001, no bubble.
- Illegal op=4'hD, a=5, b=7 -> result=0, onz=3'b001, err=1 for that result only; the following MOVB b=8'h80 gives err=0, onz=3'b010.
- rst pulsed 4 cycles into a MUL -> out_valid, result, onz and err go to 0 immediately without waiting for a clock edge; in_ready=1 after release; no stale result ever appears.
